// File: rtl/ps_pkg.sv
// Shared definitions for the power-sense chain: default widths and the
// window fill-state encoding also used by the status register block.
package ps_pkg;

    localparam int unsigned PS_IN_W     = 32'd16;
    localparam int unsigned PS_SQ_W     = 32'd32;
    localparam int unsigned PS_LOG2_WIN = 32'd6;

    typedef enum logic [1:0] {
        PS_EMPTY   = 2'd0,
        PS_FILLING = 2'd1,
        PS_FULL    = 2'd2
    } ps_fill_state_e;

    // Fill counts are passed at 11 bits, enough for the largest legal window.
    function automatic ps_fill_state_e ps_fill_state(input logic [10:0] fill,
                                                     input logic [10:0] depth);
        ps_fill_state_e st;
        if (fill == 11'd0) begin
            st = PS_EMPTY;
        end else if (fill >= depth) begin
            st = PS_FULL;
        end else begin
            st = PS_FILLING;
        end
        return st;
    endfunction

endpackage

// File: rtl/ps_window_accum_if.sv
// Sample-in / energy-out bundle between the squaring stage, the window
// accumulator and the downstream detector.
interface ps_window_accum_if
    import ps_pkg::*;
#(
    parameter int unsigned input_width = PS_SQ_W,
    parameter int unsigned log2_win    = PS_LOG2_WIN,
    parameter int unsigned sum_width   = input_width + log2_win
);
    logic                   clr;
    logic [input_width-1:0] din;
    logic                   din_valid;
    logic [sum_width-1:0]   sum;
    logic [input_width-1:0] avg;
    logic                   dout_valid;
    logic                   full;

    modport master (output clr, din, din_valid,
                    input  sum, avg, dout_valid, full);
    modport slave  (input  clr, din, din_valid,
                    output sum, avg, dout_valid, full);
endinterface

// File: rtl/ps_delay_ram.sv
// Circular sample store: synchronous write, asynchronous read of the entry
// at the write pointer, which is the oldest sample in the window.
module ps_delay_ram #(
    parameter int unsigned input_width = 32'd32,
    parameter int unsigned log2_win    = 32'd6
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [log2_win-1:0]    addr,
    input  logic [input_width-1:0] wdata,
    output logic [input_width-1:0] rdata
);
    localparam int unsigned DEPTH = 32'd1 << log2_win;

    logic [input_width-1:0] mem_r [0:DEPTH-1];

    // Storage has no reset: stale entries are masked by the fill counter.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/ps_window_accum.sv
// Sliding-window energy accumulator: running sum over the last 2**log2_win
// accepted squared samples plus the truncated mean power.
module ps_window_accum
    import ps_pkg::*;
#(
    parameter int unsigned input_width = PS_SQ_W,
    parameter int unsigned log2_win    = PS_LOG2_WIN,
    parameter int unsigned sum_width   = input_width + log2_win
) (
    input  logic              clk,
    input  logic              rst,
    ps_window_accum_if.slave  bus
);
    localparam int unsigned N  = 32'd1 << log2_win;
    localparam int unsigned FW = log2_win + 32'd1;
    localparam logic [FW-1:0] FILL_MAX = FW'(N);

    logic [1:0]             rst_sync_r;
    logic                   rst_n_s;
    logic [log2_win-1:0]    wptr_r;
    logic [FW-1:0]          fill_r;
    logic [sum_width-1:0]   sum_r;
    logic [input_width-1:0] avg_r;
    logic                   dout_valid_r;
    logic                   full_r;

    ps_fill_state_e         state_s;
    logic                   accept_s;
    logic [input_width-1:0] old_s;
    logic [sum_width-1:0]   out_s;
    logic [sum_width-1:0]   sum_nxt_s;
    logic [FW-1:0]          fill_nxt_s;

    // Reset asserts straight through, releases two clocks later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_r[1];

    ps_delay_ram #(
        .input_width (input_width),
        .log2_win    (log2_win)
    ) u_ram (
        .clk   (clk),
        .we    (accept_s),
        .addr  (wptr_r),
        .wdata (bus.din),
        .rdata (old_s)
    );

    // Next running sum and saturating fill count for an accepted sample.
    always_comb begin
        state_s  = ps_fill_state(11'(fill_r), 11'(N));
        accept_s = bus.din_valid & ~bus.clr;
        if (state_s == PS_FULL) begin
            out_s = sum_width'(old_s);
        end else begin
            out_s = '0;
        end
        sum_nxt_s = sum_r + sum_width'(bus.din) - out_s;
        if (fill_r == FILL_MAX) begin
            fill_nxt_s = fill_r;
        end else begin
            fill_nxt_s = fill_r + FW'(1);
        end
    end

    // Window state and output registers; clr wins over a same-cycle sample.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            wptr_r       <= '0;
            fill_r       <= '0;
            sum_r        <= '0;
            avg_r        <= '0;
            dout_valid_r <= 1'b0;
            full_r       <= 1'b0;
        end else if (bus.clr) begin
            wptr_r       <= '0;
            fill_r       <= '0;
            sum_r        <= '0;
            avg_r        <= '0;
            dout_valid_r <= 1'b0;
            full_r       <= 1'b0;
        end else if (accept_s) begin
            wptr_r       <= wptr_r + log2_win'(1);
            fill_r       <= fill_nxt_s;
            sum_r        <= sum_nxt_s;
            avg_r        <= input_width'(sum_nxt_s >> log2_win);
            dout_valid_r <= (fill_nxt_s == FILL_MAX);
            full_r       <= (fill_nxt_s == FILL_MAX);
        end else begin
            dout_valid_r <= 1'b0;
        end
    end

    assign bus.sum        = sum_r;
    assign bus.avg        = avg_r;
    assign bus.dout_valid = dout_valid_r;
    assign bus.full       = full_r;

endmodule
